// File: rtl/weight_bram_banked_if.sv
// Load/read bus of the banked weight store: valid/ready weight stream in, wide multi-lane read out.
interface weight_bram_banked_if #(
  parameter int WEIGHT_WIDTH    = 8,
  parameter int NUM_BANKS       = 4,
  parameter int BRAM_ADDR_WIDTH = 8
);
  logic                              load_start;
  logic                              wr_valid;
  logic [WEIGHT_WIDTH-1:0]           wr_data;
  logic                              wr_ready;
  logic                              load_done;
  logic                              rd_en;
  logic [BRAM_ADDR_WIDTH-1:0]        rd_addr;
  logic [NUM_BANKS*WEIGHT_WIDTH-1:0] rd_data;
  logic                              rd_valid;
  logic                              rd_err;

  modport master (
    output load_start, wr_valid, wr_data, rd_en, rd_addr,
    input  wr_ready, load_done, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  load_start, wr_valid, wr_data, rd_en, rd_addr,
    output wr_ready, load_done, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/weight_bram_banked.sv
// Banked weight store: a linear weight stream is interleaved across NUM_BANKS banks,
// and every read returns the same word address from all banks at once.
module weight_bram_banked #(
  parameter int WEIGHT_WIDTH    = 8,
  parameter int NUM_BANKS       = 4,
  parameter int BANK_DEPTH      = 196,
  parameter int BRAM_ADDR_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  weight_bram_banked_if.slave bus
);

  localparam int BANK_PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BANK_PTR_W-1:0]      LAST_BANK = BANK_PTR_W'(NUM_BANKS - 1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_WORD = BRAM_ADDR_WIDTH'(BANK_DEPTH - 1);
  localparam logic [BRAM_ADDR_WIDTH:0]   DEPTH_EXT = (BRAM_ADDR_WIDTH + 1)'(BANK_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  logic [WEIGHT_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

  state_e                        state_q;
  logic [BANK_PTR_W-1:0]         bank_ptr_q, bank_ptr_d;
  logic [BRAM_ADDR_WIDTH-1:0]    word_ptr_q, word_ptr_d;
  logic                          wr_ready_q, load_done_q;
  logic                          beat, last_beat, addr_ok;
  logic [NUM_BANKS*WEIGHT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                          rd_valid_q, rd_err_q;

  // load_start suppresses a coincident beat so a restart never stores stale data
  always_comb begin
    beat       = bus.wr_valid & wr_ready_q & ~bus.load_start;
    last_beat  = (bank_ptr_q == LAST_BANK) && (word_ptr_q == LAST_WORD);
    bank_ptr_d = bank_ptr_q + BANK_PTR_W'(1);
    word_ptr_d = word_ptr_q;
    if (bank_ptr_q == LAST_BANK) begin
      bank_ptr_d = '0;
      word_ptr_d = word_ptr_q + BRAM_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      mem[bank_ptr_q][word_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bank_ptr_q  <= '0;
      word_ptr_q  <= '0;
      wr_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else if (bus.load_start) begin
      state_q     <= LOAD;
      bank_ptr_q  <= '0;
      word_ptr_q  <= '0;
      wr_ready_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (beat) begin
            if (last_beat) begin
              state_q     <= DONE;
              bank_ptr_q  <= '0;
              word_ptr_q  <= '0;
              wr_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              bank_ptr_q <= bank_ptr_d;
              word_ptr_q <= word_ptr_d;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Out-of-range addresses never touch the array and return an all-zero word
  always_comb begin
    addr_ok   = {1'b0, bus.rd_addr} < DEPTH_EXT;
    rd_data_d = '0;
    if (addr_ok) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_data_d[b*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem[b][bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= rd_data_d;
        rd_err_q  <= ~addr_ok;
      end
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.load_done = load_done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_err    = rd_err_q;

endmodule

// File: tb/tb_weight_bram_banked.sv
// Directed bench for weight_bram_banked: full/gapped loads, lane mapping, read timing,
// out-of-range reads, read-first collisions, load_start priority and mid-load reset.
module tb_weight_bram_banked;

  localparam int W     = 8;
  localparam int NB    = 4;
  localparam int DEPTH = 196;
  localparam int AW    = 8;
  localparam int TOTAL = NB * DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   accepted;
  int   cyc;
  logic go;
  logic wv;

  weight_bram_banked_if #(.WEIGHT_WIDTH(W), .NUM_BANKS(NB), .BRAM_ADDR_WIDTH(AW)) bus ();

  weight_bram_banked #(
    .WEIGHT_WIDTH(W), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH), .BRAM_ADDR_WIDTH(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive inputs, then advance to just after the next rising edge
  task automatic applyStimulus(input logic ls, input logic wvalid, input logic [W-1:0] wd,
                               input logic re, input logic [AW-1:0] ra);
    bus.load_start = ls;
    bus.wr_valid   = wvalid;
    bus.wr_data    = wd;
    bus.rd_en      = re;
    bus.rd_addr    = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic readWord(input logic [AW-1:0] a, input logic [31:0] expected, input string tag);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, a);
    checkOutput({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    checkOutput({tag, "_err"}, 64'(bus.rd_err), 64'd0);
    checkOutput({tag, "_data"}, 64'(bus.rd_data), 64'(expected));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.load_start = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    rst_n          = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    checkOutput("rst_load_done", 64'(bus.load_done), 64'd0);
    checkOutput("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("rst_rd_err", 64'(bus.rd_err), 64'd0);
    checkOutput("rst_rd_data", 64'(bus.rd_data), 64'd0);
    #19 rst_n = 1'b1;

    // Full load with wr_valid held high
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    checkOutput("load1_wr_ready", 64'(bus.wr_ready), 64'd1);
    checkOutput("load1_done_low", 64'(bus.load_done), 64'd0);
    accepted = 0;
    cyc      = 0;
    while (accepted < TOTAL && cyc < 3000) begin
      go = bus.wr_ready;
      if (go && accepted == TOTAL - 1) checkOutput("load1_done_before_last", 64'(bus.load_done), 64'd0);
      applyStimulus(1'b0, 1'b1, W'(accepted), 1'b0, '0);
      if (go) accepted++;
      cyc++;
    end
    checkOutput("load1_beats", 64'(accepted), 64'(TOTAL));
    checkOutput("load1_cycles", 64'(cyc), 64'(TOTAL));
    checkOutput("load1_ready_after", 64'(bus.wr_ready), 64'd0);
    checkOutput("load1_done_after", 64'(bus.load_done), 64'd1);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, '0);
    checkOutput("load1_ready_hold", 64'(bus.wr_ready), 64'd0);
    checkOutput("load1_done_hold", 64'(bus.load_done), 64'd1);

    readWord(8'd0, 32'h03020100, "rd_addr0");
    readWord(8'd195, 32'h0F0E0D0C, "rd_addr195");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 8'd3);
    checkOutput("idle_rd_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("idle_rd_hold", 64'(bus.rd_data), 64'h0F0E0D0C);

    readWord(8'd5, 32'h17161514, "b2b_addr5");
    readWord(8'd6, 32'h1B1A1918, "b2b_addr6");
    readWord(8'd7, 32'h1F1E1D1C, "b2b_addr7");

    applyStimulus(1'b0, 1'b0, '0, 1'b1, 8'd200);
    checkOutput("oor_valid", 64'(bus.rd_valid), 64'd1);
    checkOutput("oor_err", 64'(bus.rd_err), 64'd1);
    checkOutput("oor_data", 64'(bus.rd_data), 64'd0);
    readWord(8'd1, 32'h07060504, "after_oor");

    // Read-first collision on bank 0 word 0, then load_start beating a coincident beat
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 8'd0);
    checkOutput("coll_old_data", 64'(bus.rd_data), 64'h03020100);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 8'd0);
    checkOutput("coll_new_data", 64'(bus.rd_data), 64'h030201AA);
    checkOutput("restart_ready", 64'(bus.wr_ready), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 8'd0);
    checkOutput("restart_no_write", 64'(bus.rd_data), 64'h030201AA);

    // Gapped loader: wr_valid pattern 1,0,0 repeating
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    accepted = 0;
    cyc      = 0;
    while (accepted < TOTAL && cyc < 5000) begin
      wv = (cyc % 3 == 0);
      go = bus.wr_ready && wv;
      if (go && accepted == TOTAL - 1) checkOutput("gap_done_before_last", 64'(bus.load_done), 64'd0);
      applyStimulus(1'b0, wv, W'(accepted) ^ 8'h5A, 1'b0, '0);
      if (go) accepted++;
      cyc++;
    end
    checkOutput("gap_beats", 64'(accepted), 64'(TOTAL));
    checkOutput("gap_ready_after", 64'(bus.wr_ready), 64'd0);
    checkOutput("gap_done_after", 64'(bus.load_done), 64'd1);
    readWord(8'd0, 32'h59585B5A, "gap_addr0");
    readWord(8'd195, 32'h55545756, "gap_addr195");

    // Reset 100 beats into a reload
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    accepted = 0;
    cyc      = 0;
    while (accepted < 100 && cyc < 500) begin
      go = bus.wr_ready;
      applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0, '0);
      if (go) accepted++;
      cyc++;
    end
    checkOutput("mid_ready_before_rst", 64'(bus.wr_ready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    checkOutput("mid_rst_load_done", 64'(bus.load_done), 64'd0);
    checkOutput("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("mid_rst_rd_data", 64'(bus.rd_data), 64'd0);
    #4 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, '0);
    checkOutput("post_rst_ready", 64'(bus.wr_ready), 64'd0);
    checkOutput("post_rst_done", 64'(bus.load_done), 64'd0);
    readWord(8'd0, 32'hC3C3C3C3, "post_rst_addr0");
    readWord(8'd24, 32'hC3C3C3C3, "post_rst_addr24");
    readWord(8'd25, 32'h3D3C3F3E, "post_rst_addr25");
    readWord(8'd195, 32'h55545756, "post_rst_addr195");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_bram_banked.md
Name: weight_bram_banked

Overview:
- Banked weight store for the NPU; successor to the single-port flat weight BRAM.
- Loads a linear weight stream through a valid/ready handshake and interleaves it across NUM_BANKS banks.
- Returns one word from every bank per read, so the MAC array is fed NUM_BANKS weights per cycle.
- Reads are registered and flagged valid; loading is tracked by a small FSM with a load-done indication.

Parameters:
- WEIGHT_WIDTH, 8, bits per weight word.
- NUM_BANKS, 4, number of parallel banks (read lanes); must be ≥1.
- BANK_DEPTH, 196, words per bank (default NUM_BANKS*BANK_DEPTH = 784 = 28*28).
- BRAM_ADDR_WIDTH, 8, bank word-address width; must satisfy 2^BRAM_ADDR_WIDTH ≥ BANK_DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_start  in  1  single-cycle pulse; begins a new load from weight index 0.
- wr_valid  in  1  loader has a weight on wr_data.
- wr_data  in  WEIGHT_WIDTH  weight word.
- wr_ready  out  1  block accepts a weight this cycle.
- load_done  out  1  level; all NUM_BANKS*BANK_DEPTH words written since the last load_start.
- rd_en  in  1  read request.
- rd_addr  in  BRAM_ADDR_WIDTH  bank word address, applied to all banks.
- rd_data  out  NUM_BANKS*WEIGHT_WIDTH  lane b = bank b, lane 0 in LSBs.
- rd_valid  out  1  rd_data/rd_err valid this cycle.
- rd_err  out  1  the request had rd_addr ≥ BANK_DEPTH.

Behaviour:
- Reset (async assert) forces the following:
  - FSM=IDLE; wr_ready=0, load_done=0, rd_valid=0, rd_err=0, rd_data=0.
  - Internal bank_ptr=0, word_ptr=0.
  - Memory contents are NOT cleared.
- FSM states:
  - IDLE: no load active.
  - LOAD: wr_ready=1.
  - DONE: load_done=1.
- FSM transitions:
  - load_start in any state → LOAD next cycle; bank_ptr=0, word_ptr=0, load_done=0.
  - LOAD with last beat accepted → DONE.
- Write mapping: linear weight index i goes to bank i mod NUM_BANKS, word i / NUM_BANKS.
  - On a beat (wr_valid & wr_ready): write to bank[bank_ptr][word_ptr].
  - Then bank_ptr increments; on wrap from NUM_BANKS-1 to 0, word_ptr increments.
- Last beat: bank_ptr=NUM_BANKS-1 and word_ptr=BANK_DEPTH-1.
  - Next cycle: wr_ready=0, load_done=1.
  - Pointers return to 0.
- Beats offered while wr_ready=0 are ignored and never written; wr_ready does not depend combinationally on wr_valid.
- load_start in the same cycle as a beat: load_start wins and the beat is not written.
- Reset mid-load: partial contents are retained, load_done=0, and FSM=IDLE.
- Read timing: rd_en sampled at edge N gives rd_data/rd_valid at edge N+1, in every FSM state.
  - rd_valid is a one-cycle pulse per request; back-to-back requests give back-to-back valids.
  - rd_valid=0 when no request; rd_data holds its last value.
- Out-of-range read (rd_addr ≥ BANK_DEPTH): rd_data=0 and rd_err=1 with rd_valid; memory is not accessed. rd_err=0 on in-range reads.
- Read/write collision (same bank, same word, same edge): read-first, i.e. old contents are returned; the new value is visible from the next read.
- Reads during LOAD are legal and return current contents.

Test Plan:
- Reset, then load_start and 784 beats with wr_data=i[7:0], wr_valid held high → exactly 784 beats accepted, then wr_ready=0 and load_done=1 one cycle after the last beat; rd_addr=0 → rd_data={8'h03,8'h02,8'h01,8'h00}; rd_addr=195 → {8'h0F,8'h0E,8'h0D,8'h0C} (indices 780..783).
- Loader with gaps (wr_valid toggling 1,0,0,1,...) → data map identical to the previous case; load_done asserts after exactly 784 accepted beats.
- Reads at rd_addr 5,6,7 on consecutive cycles after load → rd_valid high for 3 consecutive cycles with lanes {23,22,21,20},{27,26,25,24},{31,30,29,28}, 1-cycle latency.
- rd_addr=200 → rd_valid=1, rd_err=1, rd_data=0; the next in-range read → rd_err=0.
- During reload with wr_data=8'hAA, read word 0 in the same cycle as the bank-0/word-0 beat → old value 8'h00; a read one cycle later → lane0=8'hAA.
- rst_n low after 100 beats of a load → outputs at reset values immediately, without waiting for clk; after release, load_done=0 and wr_ready=0 until load_start; the old words at indices ≥100 are still readable.
